// File: rtl/debounce_pkg.sv
// Shared parameters and helpers for the input debounce bank.
// Defaults match the board's push-button bank.
package debounce_pkg;

  localparam int unsigned BTN_CHANNELS   = 4;
  localparam int unsigned BTN_STABLE_CNT = 4;
  localparam int unsigned BTN_PRESCALE   = 1;

  function automatic int cnt_width(input int stable_cnt);
    int w;
    w = $clog2(stable_cnt);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchroniser, stability counter,
// clean level and registered rise/fall pulses.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int   STABLE_CNT  = BTN_STABLE_CNT,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic sig_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = cnt_width(STABLE_CNT);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT - 1);

  logic          s1_q, sync_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (tick_i) begin
      if (sync_q == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        level_d = sync_q;
        cnt_d   = '0;
        rise_d  = sync_q;
        fall_d  = ~sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= RESET_LEVEL;
      sync_q  <= RESET_LEVEL;
      level_q <= RESET_LEVEL;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= sig_i;
      sync_q  <= s1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel debounce bank: shared sample-tick prescaler feeding
// independent per-channel qualifiers.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int                   CHANNELS    = BTN_CHANNELS,
  parameter int                   STABLE_CNT  = BTN_STABLE_CNT,
  parameter int                   PRESCALE    = BTN_PRESCALE,
  parameter logic                 RESET_LEVEL = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] sig_i,
  output logic [CHANNELS-1:0] level_o,
  output logic [CHANNELS-1:0] rise_o,
  output logic [CHANNELS-1:0] fall_o,
  output logic                any_change_o
);

  localparam int PW = cnt_width(PRESCALE);
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  if (STABLE_CNT < 1) begin : g_bad_stable
    $error("debounce_bank: STABLE_CNT must be >= 1");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("debounce_bank: PRESCALE must be >= 1");
  end

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  // With PRESCALE=1 the counter stays at 0 == PRE_MAX, so tick is constant.
  assign tick  = (pre_q == PRE_MAX);
  assign pre_d = tick ? '0 : pre_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) pre_q <= '0;
    else     pre_q <= pre_d;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    debounce_chan #(
      .STABLE_CNT (STABLE_CNT),
      .RESET_LEVEL(RESET_LEVEL)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .tick_i (tick),
      .sig_i  (sig_i[c]),
      .level_o(level_o[c]),
      .rise_o (rise_o[c]),
      .fall_o (fall_o[c])
    );
  end

  assign any_change_o = |(rise_o | fall_o);

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: per-cycle vector table plus
// hand sequences for reset, reset mid-count and prescaled sampling.
module tb_debounce_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sig = 4'h0;
  logic [3:0] lvl, rise, fall;
  logic       any;
  logic [3:0] sig2 = 4'h0;
  logic [3:0] lvl2, rise2, fall2;
  logic       any2;

  int checks = 0;
  int failures = 0;
  int ph_m = 0;

  always #5 clk = ~clk;

  debounce_bank #(
    .CHANNELS(4), .STABLE_CNT(4), .PRESCALE(1), .RESET_LEVEL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .sig_i(sig),
    .level_o(lvl), .rise_o(rise), .fall_o(fall), .any_change_o(any)
  );

  debounce_bank #(
    .CHANNELS(4), .STABLE_CNT(4), .PRESCALE(8), .RESET_LEVEL(1'b0)
  ) dut_ps (
    .clk(clk), .rst(rst), .sig_i(sig2),
    .level_o(lvl2), .rise_o(rise2), .fall_o(fall2), .any_change_o(any2)
  );

  // Reference prescaler phase: a tick happens at an edge where ph_m==7.
  always @(posedge clk) begin
    if (rst) ph_m <= 0;
    else     ph_m <= (ph_m == 7) ? 0 : ph_m + 1;
  end

  typedef struct {
    logic [3:0] s;
    logic [3:0] l;
    logic [3:0] r;
    logic [3:0] f;
  } vec_t;

  vec_t vq[$];

  function automatic void add(logic [3:0] s, logic [3:0] l,
                              logic [3:0] r, logic [3:0] f);
    vec_t v;
    v.s = s; v.l = l; v.r = r; v.f = f;
    vq.push_back(v);
  endfunction

  function automatic void add_n(logic [3:0] s, logic [3:0] l, int n);
    for (int i = 0; i < n; i++) add(s, l, 4'h0, 4'h0);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(string tag, logic [3:0] l, logic [3:0] r,
                         logic [3:0] f);
    chk({tag, ".level"}, 32'(lvl), 32'(l));
    chk({tag, ".rise"}, 32'(rise), 32'(r));
    chk({tag, ".fall"}, 32'(fall), 32'(f));
    chk({tag, ".any"}, 32'(any), 32'(|(r | f)));
  endtask

  initial begin
    int nt;
    int k;
    logic tk;

    // Reset with all inputs high, then let them qualify.
    sig = 4'hF;
    sig2 = 4'h0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("reset", 4'h0, 4'h0, 4'h0);
      chk("reset.ps_level", 32'(lvl2), 32'h0);
    end
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_all("post_reset", (i >= 5) ? 4'hF : 4'h0,
              (i == 5) ? 4'hF : 4'h0, 4'h0);
      @(negedge clk);
    end

    // Back to a quiet all-low state.
    sig = 4'h0;
    rst = 1'b1;
    repeat (3) step();
    @(negedge clk) rst = 1'b0;
    repeat (3) step();

    // Clean step on ch0.
    add_n(4'b0001, 4'b0000, 5);
    add(4'b0001, 4'b0001, 4'b0001, 4'b0000);
    add_n(4'b0001, 4'b0001, 2);
    // ch1 high for 3 cycles only.
    add_n(4'b0011, 4'b0001, 3);
    add_n(4'b0001, 4'b0001, 6);
    // ch2 bounce 1,0,1,0,1 then steady.
    add_n(4'b0101, 4'b0001, 1);
    add_n(4'b0001, 4'b0001, 1);
    add_n(4'b0101, 4'b0001, 1);
    add_n(4'b0001, 4'b0001, 1);
    add_n(4'b0101, 4'b0001, 5);
    add(4'b0101, 4'b0101, 4'b0100, 4'b0000);
    add_n(4'b0101, 4'b0101, 2);
    // Move to 1000, then simultaneous 1000 -> 0001.
    add_n(4'b1000, 4'b0101, 5);
    add(4'b1000, 4'b1000, 4'b1000, 4'b0101);
    add_n(4'b1000, 4'b1000, 2);
    add_n(4'b0001, 4'b1000, 5);
    add(4'b0001, 4'b0001, 4'b0001, 4'b1000);
    add_n(4'b0001, 4'b0001, 2);

    foreach (vq[i]) begin
      @(negedge clk) sig = vq[i].s;
      step();
      chk_all($sformatf("vec%0d", i), vq[i].l, vq[i].r, vq[i].f);
    end

    // Reset in the middle of qualifying ch3 (ch0 already high).
    @(negedge clk) sig = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("midcnt_pre", 4'b0001, 4'h0, 4'h0);
      @(negedge clk);
    end
    rst = 1'b1;
    step();
    chk_all("midcnt_rst", 4'h0, 4'h0, 4'h0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_all("midcnt_post", (i >= 5) ? 4'b1001 : 4'h0,
              (i == 5) ? 4'b1001 : 4'h0, 4'h0);
      @(negedge clk);
    end

    // Prescaled bank: 1-clk glitches between ticks are ignored.
    for (int g = 0; g < 3; g++) begin
      k = 0;
      while (ph_m != 2 && k < 20) begin
        @(negedge clk);
        k++;
      end
      sig2[0] = 1'b1;
      @(negedge clk) sig2[0] = 1'b0;
      for (int i = 0; i < 12; i++) begin
        step();
        chk("ps_glitch.level", 32'(lvl2), 32'h0);
        chk("ps_glitch.pulse", 32'({rise2, fall2, any2}), 32'h0);
        @(negedge clk);
      end
    end

    // Prescaled held step: level changes on the 4th tick once sync is new.
    sig2[0] = 1'b1;
    nt = 0;
    k = 0;
    while (nt < 5 && k < 80) begin
      tk = (ph_m == 7);
      step();
      if (k >= 2 && tk) nt++;
      chk("ps_step.level", 32'(lvl2[0]), 32'(nt >= 4));
      chk("ps_step.rise", 32'(rise2[0]),
          32'(k >= 2 && tk && nt == 4));
      chk("ps_step.fall", 32'(fall2), 32'h0);
      @(negedge clk);
      k++;
    end
    chk("ps_step.timeout", 32'(nt >= 5), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel input conditioner for the game's push-button and mole-sensor inputs. Each channel synchronises an asynchronous input, qualifies it with a saturating stability counter advanced on a shared prescaled sample tick, and produces a clean level plus single-cycle rise and fall pulses. It replaces per-button single-channel debouncers with one bank that sits between the board pins and the game FSM. The FSM consumes pulses directly, with no further edge detection.

## Interface
- CHANNELS, 4: number of independent input channels, ≥1
- STABLE_CNT, 4: consecutive agreeing sample ticks required to accept a new level, ≥1
- PRESCALE, 1: clock cycles per sample tick, ≥1 (1 = sample every cycle)
- RESET_LEVEL, 1'b0: level loaded into synchronisers and level_o on reset

- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- sig_i  in  CHANNELS  raw asynchronous inputs
- level_o  out  CHANNELS  debounced level
- rise_o  out  CHANNELS  one-clk pulse when level_o goes 0→1
- fall_o  out  CHANNELS  one-clk pulse when level_o goes 1→0
- any_change_o  out  1  OR of all rise_o and fall_o bits, same cycle

## Operation
- Per channel, a 2-flop synchroniser samples sig_i each clk. The second stage, sync, is the only value the qualifier sees.
- The shared prescaler counts 0..PRESCALE-1 and wraps. tick is asserted in the cycle the prescaler equals PRESCALE-1. With PRESCALE=1, tick is constantly 1.
- Per channel, on a cycle with tick:
  - sync == level_o: cnt ← 0.
  - sync != level_o and cnt == STABLE_CNT-1: level_o ← sync, cnt ← 0, pulse the matching rise_o or fall_o bit.
  - otherwise: cnt ← cnt+1.
- Cycles without tick: cnt and level_o hold.
- Any single disagreeing-to-agreeing sample restarts qualification. This is strict consecutive agreement, with no partial credit.
- cnt width is max(1, $clog2(STABLE_CNT)). cnt never exceeds STABLE_CNT-1, so no wrap is possible.
- rise_o and fall_o are registered, high for exactly one clk, and coincide with the level_o update edge. They are 0 on every other cycle, including all non-tick cycles.
- Channels are fully independent. Simultaneous changes on several channels produce pulses in the same cycle.

## Timing
- Reset (rst high at a clk edge) forces:
  - synchronisers and level_o to RESET_LEVEL on every bit
  - cnt and prescaler to 0
  - rise_o, fall_o, any_change_o to 0
- Because synchronisers reset to RESET_LEVEL, reset release never generates a pulse unless the input differs and then qualifies.
- Reset asserted mid-qualification discards the partial count. The channel re-qualifies from zero after release.
- Latency at PRESCALE=1: the edge that first samples the new sig_i is edge 0. level_o and the pulse change at edge STABLE_CNT+1.
- Latency at PRESCALE>1: 2 clk of synchronisation plus STABLE_CNT ticks. Exact phase depends on the prescaler position, with a spread of at most PRESCALE-1 clk.
- Input glitches shorter than STABLE_CNT consecutive ticks never reach level_o.
- At PRESCALE>1, glitches that fall entirely between ticks are invisible.

## Structure
- Package debounce_pkg holds:
  - function cnt_width(stable_cnt), returning max(1, $clog2(stable_cnt))
  - localparam defaults for the board's button bank (CHANNELS=4, STABLE_CNT=4, PRESCALE=1)
- Sub-module debounce_chan contains one synchroniser, cnt, level and pulse logic, with tick as an input.
- debounce_bank owns the prescaler, generates CHANNELS instances of debounce_chan, and ORs pulses into any_change_o.
- Elaboration-time asserts reject STABLE_CNT<1 and PRESCALE<1.

## Test plan
Defaults CHANNELS=4, STABLE_CNT=4, PRESCALE=1, RESET_LEVEL=0 unless stated.
- Reset: rst high 3 cycles with sig_i=4'hF -> all outputs 0 during reset. After release, rise_o=4'hF exactly once, at edge 5 after release, and level_o=4'hF thereafter.
- Clean step: sig_i[0] 0→1 held -> level_o[0] and rise_o[0] change at edge 5 (edge 0 = first sample). rise_o[0] lasts 1 cycle; fall_o stays 0.
- Glitch/bounce:
  - sig_i[1] high 3 cycles then low -> no change, no pulses.
  - sig_i[2] pattern 1,0,1,0,1 then steady 1 -> exactly one rise_o[2], at edge 5 after the final 0→1.
- Simultaneous: with level_o=4'b1000, sig_i goes 4'b1000→4'b0001 in one cycle -> rise_o=4'b0001 and fall_o=4'b1000 in the same cycle, any_change_o high for 1 cycle.
- Prescale: PRESCALE=8, 1-clk pulses on sig_i[0] placed away from the tick cycle -> ignored. A held step -> level_o changes on the 4th tick after sync updates.
- Reset mid-count: step sig_i[3], assert rst at edge 3 for 1 cycle with sig_i still high -> no pulse before release. rise_o[3] at edge 5 after release.
